reg_bank: RTL and testbench

//  Parametrised multi-entry register bank: next generation of the single 16-bit

---
 rtl/reg_bank.sv | 114 +++++++++++
 tb/tb_reg_bank.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// Multi-entry register bank: one write port with load/inc/dec/clear ops and
// two registered read ports whose reads see the same-edge write (write-first).
module reg_bank #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [1:0]               wr_op,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en_a,
    input  logic [ADDR_W-1:0]        rd_addr_a,
    output logic [WIDTH-1:0]         rd_data_a,
    output logic                     rd_valid_a,
    input  logic                     rd_en_b,
    input  logic [ADDR_W-1:0]        rd_addr_b,
    output logic [WIDTH-1:0]         rd_data_b,
    output logic                     rd_valid_b,
    output logic [(2**ADDR_W)-1:0]   entry_vld,
    output logic                     wrap
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] entry_vld_q, entry_vld_d;
    logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
    logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
    logic             rd_valid_a_q, rd_valid_a_d;
    logic             rd_valid_b_q, rd_valid_b_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] wr_old_s;
    logic [WIDTH-1:0] wr_res_s;

    // Next-state: apply the write, then read from the post-write image so
    // a same-address read returns the freshly written value.
    always_comb begin
        mem_d        = mem_q;
        entry_vld_d  = entry_vld_q;
        wrap_d       = 1'b0;
        wr_old_s     = mem_q[wr_addr];
        wr_res_s     = wr_old_s;
        rd_data_a_d  = rd_data_a_q;
        rd_data_b_d  = rd_data_b_q;
        rd_valid_a_d = rd_en_a;
        rd_valid_b_d = rd_en_b;

        case (wr_op)
            OP_LOAD: wr_res_s = wr_data;
            OP_INC:  wr_res_s = wr_old_s + WIDTH'(1);
            OP_DEC:  wr_res_s = wr_old_s - WIDTH'(1);
            OP_CLR:  wr_res_s = '0;
            default: wr_res_s = wr_old_s;
        endcase

        if (wr_en) begin
            mem_d[wr_addr]       = wr_res_s;
            entry_vld_d[wr_addr] = (wr_op != OP_CLR);
            wrap_d = ((wr_op == OP_INC) && (wr_old_s == {WIDTH{1'b1}})) ||
                     ((wr_op == OP_DEC) && (wr_old_s == '0));
        end else begin
            wrap_d = 1'b0;
        end

        if (rd_en_a) begin
            rd_data_a_d = mem_d[rd_addr_a];
        end else begin
            rd_data_a_d = rd_data_a_q;
        end

        if (rd_en_b) begin
            rd_data_b_d = mem_d[rd_addr_b];
        end else begin
            rd_data_b_d = rd_data_b_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q        <= '{default: '0};
            entry_vld_q  <= '0;
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            entry_vld_q  <= entry_vld_d;
            rd_data_a_q  <= rd_data_a_d;
            rd_data_b_q  <= rd_data_b_d;
            rd_valid_a_q <= rd_valid_a_d;
            rd_valid_b_q <= rd_valid_b_d;
            wrap_q       <= wrap_d;
        end
    end

    assign rd_data_a  = rd_data_a_q;
    assign rd_data_b  = rd_data_b_q;
    assign rd_valid_a = rd_valid_a_q;
    assign rd_valid_b = rd_valid_b_q;
    assign entry_vld  = entry_vld_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed vector table for the corner cases
// plus randomized traffic against a behavioural array model.
module tb_reg_bank;

    localparam int WIDTH  = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [1:0]        wr_op = 2'b00;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [WIDTH-1:0]  wr_data = '0;
    logic              rd_en_a = 1'b0;
    logic [ADDR_W-1:0] rd_addr_a = '0;
    logic [WIDTH-1:0]  rd_data_a;
    logic              rd_valid_a;
    logic              rd_en_b = 1'b0;
    logic [ADDR_W-1:0] rd_addr_b = '0;
    logic [WIDTH-1:0]  rd_data_b;
    logic              rd_valid_b;
    logic [DEPTH-1:0]  entry_vld;
    logic              wrap;

    int errors = 0;
    int checks = 0;

    reg_bank #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
        .entry_vld(entry_vld), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  op;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        rea;
        logic [2:0]  raa;
        logic        reb;
        logic [2:0]  rab;
        logic [15:0] ea;
        logic        eva;
        logic [15:0] eb;
        logic        evb;
        logic [7:0]  evld;
        logic        ewrap;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] op, input logic [2:0] wa,
                         input logic [15:0] wd, input logic rea, input logic [2:0] raa,
                         input logic reb, input logic [2:0] rab);
        wr_en = we; wr_op = op; wr_addr = wa; wr_data = wd;
        rd_en_a = rea; rd_addr_a = raa; rd_en_b = reb; rd_addr_b = rab;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [15:0] ea, input logic eva,
                             input logic [15:0] eb, input logic evb,
                             input logic [7:0] evld, input logic ewrap);
        chk({tag, ".rd_data_a"}, 32'(rd_data_a), 32'(ea));
        chk({tag, ".rd_valid_a"}, 32'(rd_valid_a), 32'(eva));
        chk({tag, ".rd_data_b"}, 32'(rd_data_b), 32'(eb));
        chk({tag, ".rd_valid_b"}, 32'(rd_valid_b), 32'(evb));
        chk({tag, ".entry_vld"}, 32'(entry_vld), 32'(evld));
        chk({tag, ".wrap"}, 32'(wrap), 32'(ewrap));
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] op, input logic [2:0] wa,
                                input logic [15:0] wd, input logic rea, input logic [2:0] raa,
                                input logic reb, input logic [2:0] rab,
                                input logic [15:0] ea, input logic eva,
                                input logic [15:0] eb, input logic evb,
                                input logic [7:0] evld, input logic ewrap);
        vec_t v;
        v.we = we; v.op = op; v.wa = wa; v.wd = wd;
        v.rea = rea; v.raa = raa; v.reb = reb; v.rab = rab;
        v.ea = ea; v.eva = eva; v.eb = eb; v.evb = evb; v.evld = evld; v.ewrap = ewrap;
        return v;
    endfunction

    // Random traffic against an array model; the model's values describe the
    // state right after each edge.
    task automatic random_phase(input int n);
        logic [15:0] m_mem [DEPTH];
        logic [7:0]  m_vld;
        logic [15:0] m_a, m_b, old;
        logic        m_va, m_vb, m_wrap;
        logic        we, rea, reb;
        logic [1:0]  op;
        logic [2:0]  wa, raa, rab;
        logic [15:0] wd;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0000;
        m_vld = 8'h00; m_a = 16'h0000; m_b = 16'h0000;
        for (int c = 0; c < n; c++) begin
            we  = ($urandom_range(0, 3) != 0);
            op  = 2'($urandom_range(0, 3));
            wa  = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: wd = 16'hFFFF;
                1: wd = 16'h0000;
                default: wd = 16'($urandom);
            endcase
            rea = ($urandom_range(0, 2) != 0);
            reb = ($urandom_range(0, 2) != 0);
            raa = ($urandom_range(0, 1) == 0) ? wa : 3'($urandom_range(0, 7));
            rab = ($urandom_range(0, 1) == 0) ? wa : 3'($urandom_range(0, 7));
            drive(we, op, wa, wd, rea, raa, reb, rab);

            m_wrap = 1'b0;
            if (we) begin
                old = m_mem[wa];
                if (op == 2'd0) begin
                    m_mem[wa] = wd; m_vld[wa] = 1'b1;
                end else if (op == 2'd1) begin
                    m_mem[wa] = 16'((32'(old) + 32'd1) % 32'd65536);
                    m_wrap = (m_mem[wa] == 16'h0000); m_vld[wa] = 1'b1;
                end else if (op == 2'd2) begin
                    m_mem[wa] = 16'((32'(old) + 32'd65535) % 32'd65536);
                    m_wrap = (m_mem[wa] == 16'hFFFF); m_vld[wa] = 1'b1;
                end else begin
                    m_mem[wa] = 16'h0000; m_vld[wa] = 1'b0;
                end
            end
            m_va = rea; m_vb = reb;
            if (rea) m_a = m_mem[raa];
            if (reb) m_b = m_mem[rab];

            tick();
            check_all($sformatf("rand%0d", c), m_a, m_va, m_b, m_vb, m_vld, m_wrap);
        end
    endtask

    initial begin
        // reset test: state held in reset, then traffic and a mid-cycle pulse
        drive(1'b0, 2'd0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0);
        #2;
        check_all("rst_hold", 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'd0, 3'd5, 16'h5A5A, 1'b1, 3'd5, 1'b1, 3'd5);
        tick();
        chk("pre_rst.rd_data_a", 32'(rd_data_a), 32'h5A5A);
        drive(1'b1, 2'd2, 3'd6, 16'h0000, 1'b1, 3'd5, 1'b0, 3'd0);
        tick();
        chk("pre_rst.wrap", 32'(wrap), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("rst_async", 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 2'd0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 3'd0, 16'h0000, 1'b1, 3'd5, 1'b0, 3'd0);
        tick();
        check_all("rst_read5", 16'h0000, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0);

        //            we    op     wa    wd        rea  raa   reb  rab   ea        eva  eb        evb  vld    wrap
        vecs[0]  = mk(1'b1, 2'd0, 3'd3, 16'hBEEF, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h08, 1'b0);
        vecs[1]  = mk(1'b0, 2'd0, 3'd0, 16'h0000, 1'b1, 3'd3, 1'b0, 3'd0, 16'hBEEF, 1'b1, 16'h0000, 1'b0, 8'h08, 1'b0);
        vecs[2]  = mk(1'b1, 2'd0, 3'd2, 16'h1234, 1'b0, 3'd0, 1'b1, 3'd2, 16'hBEEF, 1'b0, 16'h1234, 1'b1, 8'h0C, 1'b0);
        vecs[3]  = mk(1'b1, 2'd0, 3'd1, 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd0, 16'hBEEF, 1'b0, 16'h1234, 1'b0, 8'h0E, 1'b0);
        vecs[4]  = mk(1'b1, 2'd1, 3'd1, 16'h0000, 1'b1, 3'd1, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h1234, 1'b0, 8'h0E, 1'b1);
        vecs[5]  = mk(1'b1, 2'd2, 3'd1, 16'h0000, 1'b0, 3'd0, 1'b1, 3'd1, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 8'h0E, 1'b1);
        vecs[6]  = mk(1'b1, 2'd0, 3'd1, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 8'h0E, 1'b0);
        vecs[7]  = mk(1'b1, 2'd0, 3'd0, 16'h00AA, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 8'h0F, 1'b0);
        vecs[8]  = mk(1'b1, 2'd3, 3'd0, 16'h0000, 1'b1, 3'd0, 1'b1, 3'd0, 16'h0000, 1'b1, 16'h0000, 1'b1, 8'h0E, 1'b0);
        vecs[9]  = mk(1'b0, 2'd0, 3'd0, 16'h0000, 1'b1, 3'd3, 1'b0, 3'd0, 16'hBEEF, 1'b1, 16'h0000, 1'b0, 8'h0E, 1'b0);
        vecs[10] = mk(1'b0, 2'd0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 8'h0E, 1'b0);
        vecs[11] = mk(1'b0, 2'd0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 8'h0E, 1'b0);
        vecs[12] = mk(1'b0, 2'd0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 8'h0E, 1'b0);
        vecs[13] = mk(1'b1, 2'd2, 3'd5, 16'h0000, 1'b0, 3'd0, 1'b1, 3'd5, 16'hBEEF, 1'b0, 16'hFFFF, 1'b1, 8'h2E, 1'b1);
        vecs[14] = mk(1'b0, 2'd0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0, 16'hBEEF, 1'b0, 16'hFFFF, 1'b0, 8'h2E, 1'b0);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].we, vecs[i].op, vecs[i].wa, vecs[i].wd,
                  vecs[i].rea, vecs[i].raa, vecs[i].reb, vecs[i].rab);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eva, vecs[i].eb,
                      vecs[i].evb, vecs[i].evld, vecs[i].ewrap);
        end

        // reset again mid-traffic so the model starts from a known state
        drive(1'b1, 2'd1, 3'd4, 16'h0000, 1'b1, 3'd3, 1'b1, 3'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("rst_mid", 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0);
        tick();

        random_phase(400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
